// File: rtl/wired_pkg.sv
// Shared types and helpers for the two-wide fetch-to-decode instruction queue.
package wired_pkg;

  localparam int DEC_W      = 2;
  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic                  intr;
  } inst_pkt_t;

  function automatic logic [1:0] popcount2(input logic [DEC_W-1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/wired_iq_bank.sv
// One bank of the instruction queue: DEPTH entries, one write port, one asynchronous read port.
module wired_iq_bank #(
  parameter int DEPTH = 8,
  parameter int W     = 65,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wired_inst_queue.sv
// Two-wide instruction queue between fetch and decode: compacts sparse fetch masks,
// presents up to two instructions per cycle in program order, empties on flush.
module wired_inst_queue
  import wired_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic [DEC_W-1:0]        f_mask,
  input  logic [DEC_W*PC_W-1:0]   f_pc,
  input  logic [DEC_W*INST_W-1:0] f_inst,
  input  logic                    f_intr,
  output logic [DEC_W-1:0]        d_valid,
  input  logic                    d_ready,
  output logic [DEC_W*PC_W-1:0]   d_pc,
  output logic [DEC_W*INST_W-1:0] d_inst,
  output logic [DEC_W-1:0]        d_intr,
  input  logic                    flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              intr;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr1, rd_ptr1, count;
  logic          enq;
  logic [1:0]    enq_n, deq_n;
  entry_t        in0, in1, first_pkt, second_pkt, slot0, slot1;

  assign count   = wr_ptr - rd_ptr;
  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);

  assign f_ready = (count <= PW'(2*DEPTH-2));
  assign d_valid = {count >= PW'(2), count != '0};

  assign enq   = f_valid & f_ready & ~flush;
  assign enq_n = enq ? popcount2(f_mask) : 2'd0;
  assign deq_n = (d_ready & ~flush) ? popcount2(d_valid) : 2'd0;

  // Compaction: the first valid slot always lands at wr_ptr and carries the interrupt tag.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in0             = '{pc: f_pc[PC_W-1:0],    inst: f_inst[INST_W-1:0],      intr: 1'b0};
    in1             = '{pc: f_pc[2*PC_W-1:PC_W], inst: f_inst[2*INST_W-1:INST_W], intr: 1'b0};
    first_pkt       = f_mask[0] ? in0 : in1;
    first_pkt.intr  = f_intr;
    second_pkt      = in1;
  end

  logic          bank_we    [DEC_W];
  logic [AW-1:0] bank_waddr [DEC_W];
  logic [EW-1:0] bank_wdata [DEC_W];
  logic [AW-1:0] bank_raddr [DEC_W];
  logic [EW-1:0] bank_rdata [DEC_W];

  for (genvar b = 0; b < DEC_W; b++) begin : g_bank
    logic first_here;
    assign first_here    = (wr_ptr[0] == 1'(b));
    assign bank_we[b]    = enq & ((first_here & (f_mask != 2'b00)) |
                                  (~first_here & (f_mask == 2'b11)));
    assign bank_waddr[b] = first_here ? wr_ptr[AW:1] : wr_ptr1[AW:1];
    assign bank_wdata[b] = first_here ? first_pkt : second_pkt;
    assign bank_raddr[b] = (rd_ptr[0] == 1'(b)) ? rd_ptr[AW:1] : rd_ptr1[AW:1];

    wired_iq_bank #(.DEPTH(DEPTH), .W(EW)) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b]),
      .raddr (bank_raddr[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Rotate bank outputs so slot0 is always the oldest entry.
  assign slot0  = rd_ptr[0] ? bank_rdata[1] : bank_rdata[0];
  assign slot1  = rd_ptr[0] ? bank_rdata[0] : bank_rdata[1];
  assign d_pc   = {slot1.pc, slot0.pc};
  assign d_inst = {slot1.inst, slot0.inst};
  assign d_intr = {slot1.intr, slot0.intr};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq_n);
      rd_ptr <= rd_ptr + PW'(deq_n);
    end
  end

endmodule

// File: tb/tb_wired_inst_queue.sv
// Scoreboard bench for wired_inst_queue: directed steps, expected packets queued on enqueue.
module tb_wired_inst_queue;
  import wired_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  logic                    clk = 1'b0;
  logic                    rst, f_valid, f_ready, f_intr, d_ready, flush;
  logic [1:0]              f_mask, d_valid, d_intr;
  logic [2*PC_W-1:0]       f_pc, d_pc;
  logic [2*INST_W-1:0]     f_inst, d_inst;

  inst_pkt_t sb[$];
  int errors = 0;
  int checks = 0;
  bit last_enq;

  always #5 clk = ~clk;

  wired_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready), .f_mask(f_mask),
    .f_pc(f_pc), .f_inst(f_inst), .f_intr(f_intr), .d_valid(d_valid), .d_ready(d_ready),
    .d_pc(d_pc), .d_inst(d_inst), .d_intr(d_intr), .flush(flush)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1,
                      input logic intr);
    f_valid = 1'b1;
    f_mask  = mask;
    f_pc    = {pc1, pc0};
    f_inst  = {~pc1, ~pc0};
    f_intr  = intr;
  endtask

  task automatic idle_inputs();
    f_valid = 1'b0;
    f_mask  = 2'b00;
    f_intr  = 1'b0;
    d_ready = 1'b0;
    flush   = 1'b0;
  endtask

  // Check outputs against the model at the falling edge, then advance the model over the rising edge.
  task automatic step();
    inst_pkt_t obs, p0, p1;
    logic      exp_fr;
    logic [1:0] exp_dv;
    @(negedge clk);
    exp_fr = (sb.size() <= 2*DEPTH-2);
    exp_dv = {sb.size() >= 2, sb.size() >= 1};
    check("f_ready", f_ready, exp_fr);
    check("d_valid", d_valid, exp_dv);
    if (exp_dv[0]) begin
      obs = '{pc: d_pc[31:0], inst: d_inst[31:0], intr: d_intr[0]};
      check("slot0", obs, sb[0]);
    end
    if (exp_dv[1]) begin
      obs = '{pc: d_pc[63:32], inst: d_inst[63:32], intr: d_intr[1]};
      check("slot1", obs, sb[1]);
    end
    last_enq = 1'b0;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (d_ready) begin
        for (int k = 0; k < 2; k++) if (sb.size() > 0) void'(sb.pop_front());
      end
      if (f_valid && exp_fr) begin
        last_enq = 1'b1;
        p0 = '{pc: f_pc[31:0],  inst: f_inst[31:0],  intr: 1'b0};
        p1 = '{pc: f_pc[63:32], inst: f_inst[63:32], intr: 1'b0};
        if (f_mask == 2'b01 || f_mask == 2'b11) begin
          p0.intr = f_intr;
          sb.push_back(p0);
          if (f_mask == 2'b11) sb.push_back(p1);
        end else if (f_mask == 2'b10) begin
          p1.intr = f_intr;
          sb.push_back(p1);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    d_ready = 1'b1;
    repeat (2*DEPTH) step();
    d_ready = 1'b0;
    check("drained_empty", d_valid, 2'b00);
  endtask

  initial begin
    int sent, cyc;
    logic [31:0] next_pc;
    logic [1:0]  m;

    idle_inputs();
    f_pc   = '0;
    f_inst = '0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("reset_f_ready", f_ready, 1'b1);
    check("reset_d_valid", d_valid, 2'b00);

    // Idle, then one full packet.
    repeat (5) step();
    push(2'b11, 32'h1000, 32'h1004, 1'b0);
    step();
    idle_inputs();
    check("t1_d_valid", d_valid, 2'b11);
    check("t1_pc0", d_pc[31:0], 32'h1000);
    check("t1_pc1", d_pc[63:32], 32'h1004);
    drain();

    // Compaction of a slot1-only packet; interrupt tag on first instruction only.
    push(2'b10, 32'hdead_0000, 32'h2004, 1'b1);
    step();
    push(2'b01, 32'h2008, 32'hbeef_0000, 1'b0);
    step();
    idle_inputs();
    check("t2_pc0", d_pc[31:0], 32'h2004);
    check("t2_pc1", d_pc[63:32], 32'h2008);
    check("t2_intr", d_intr, 2'b01);
    drain();

    // Empty mask is a legal no-op.
    push(2'b00, 32'h2100, 32'h2104, 1'b1);
    step();
    idle_inputs();
    check("mask00_empty", d_valid, 2'b00);

    // Fill to capacity; an extra push is refused; one dequeue frees room.
    for (int i = 0; i < DEPTH; i++) begin
      push(2'b11, 32'h3000 + 32'(8*i), 32'h3004 + 32'(8*i), 1'b0);
      step();
    end
    check("full_f_ready", f_ready, 1'b0);
    push(2'b11, 32'h3f00, 32'h3f04, 1'b0);
    step();
    idle_inputs();
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
    check("after_deq_f_ready", f_ready, 1'b1);
    check("after_deq_pc0", d_pc[31:0], 32'h3008);
    drain();

    // Wrap-around stream with random backpressure.
    sent    = 0;
    next_pc = 32'h4000;
    m       = 2'b01;
    cyc     = 0;
    while (sent < 40 && cyc < 1000) begin
      if (sent == 39) m = 2'b01;
      push(m, next_pc, next_pc + 32'd4, 1'($urandom_range(0, 1)));
      d_ready = 1'($urandom_range(0, 1));
      step();
      if (last_enq) begin
        sent    += int'(popcount2(m));
        next_pc += 32'(4 * int'(popcount2(m)));
        m        = (m == 2'b01) ? 2'b11 : 2'b01;
      end
      cyc++;
    end
    check("wrap_all_sent", 128'(sent), 128'(40));
    drain();

    // Flush beats a simultaneous push and pop.
    push(2'b11, 32'h5000, 32'h5004, 1'b0); step();
    push(2'b11, 32'h5008, 32'h500c, 1'b0); step();
    push(2'b01, 32'h5010, 32'h5014, 1'b0); step();
    push(2'b11, 32'h5f00, 32'h5f04, 1'b0);
    d_ready = 1'b1;
    flush   = 1'b1;
    step();
    idle_inputs();
    check("flush_d_valid", d_valid, 2'b00);
    check("flush_f_ready", f_ready, 1'b1);
    repeat (2) step();

    // Single valid entry dequeued while a full packet arrives.
    push(2'b01, 32'h6000, 32'h6ff0, 1'b0);
    step();
    push(2'b11, 32'h6004, 32'h6008, 1'b0);
    d_ready = 1'b1;
    step();
    idle_inputs();
    check("t6_d_valid", d_valid, 2'b11);
    check("t6_pc0", d_pc[31:0], 32'h6004);
    drain();

    // Reset mid-operation discards contents like a flush.
    push(2'b11, 32'h7000, 32'h7004, 1'b0);
    step();
    push(2'b11, 32'h7008, 32'h700c, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    check("rst_mid_d_valid", d_valid, 2'b00);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
